// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter for the register-file write port; illegal addresses raise ERR.
// Optional macro WRARB_LOCK_EN adds the LOCK input for locked bursts.
module regfile_wr_arbiter #(
  parameter int NREQ  = 3,
  parameter int AW    = 3,
  parameter int DW    = 15,
  parameter int DEPTH = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*AW-1:0] REQ_WA,
  input  logic [NREQ*DW-1:0] REQ_WD,
`ifdef WRARB_LOCK_EN
  input  logic [NREQ-1:0]    LOCK,
`endif
  output logic [NREQ-1:0]    GNT,
  output logic [AW-1:0]      WA,
  output logic [DW-1:0]      WD,
  output logic               WE,
  output logic               ERR,
  output logic [2:0]         ERR_ID
);

  localparam logic [AW:0] depth_c = (AW+1)'(DEPTH);
  localparam logic [2:0]  last_c  = 3'(NREQ-1);

  logic [2:0]      ptr;
  logic [NREQ-1:0] gnt_c;
  logic [2:0]      gnt_idx;
  logic            found;
  logic [AW-1:0]   wa_sel;
  logic [DW-1:0]   wd_sel;
  logic            lock_sel;
  logic            legal;

  // Search offsets from ptr upward; the first requesting slot wins.
  always_comb begin
    gnt_c    = '0;
    gnt_idx  = 3'd0;
    found    = 1'b0;
    wa_sel   = '0;
    wd_sel   = '0;
    lock_sel = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && REQ[j] && (((int'(ptr) + off) % NREQ) == j)) begin
          found    = 1'b1;
          gnt_c[j] = 1'b1;
          gnt_idx  = 3'(j);
          wa_sel   = REQ_WA[j*AW +: AW];
          wd_sel   = REQ_WD[j*DW +: DW];
`ifdef WRARB_LOCK_EN
          lock_sel = LOCK[j];
`else
          lock_sel = 1'b0;
`endif
        end
      end
    end
  end

  assign GNT   = rst ? '0 : gnt_c;
  assign legal = ({1'b0, wa_sel} < depth_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= 3'd0;
      WE     <= 1'b0;
      WA     <= '0;
      WD     <= '0;
      ERR    <= 1'b0;
      ERR_ID <= 3'd0;
    end else begin
      WE  <= 1'b0;
      ERR <= 1'b0;
      if (found) begin
        // A locked transfer keeps the winner at the head of the search order.
        if (lock_sel)
          ptr <= gnt_idx;
        else
          ptr <= (gnt_idx == last_c) ? 3'd0 : gnt_idx + 3'd1;
        if (legal) begin
          WE <= 1'b1;
          WA <= wa_sel;
          WD <= wd_sel;
        end else begin
          ERR    <= 1'b1;
          ERR_ID <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - vector table, hand sequences and randomized model check of regfile_wr_arbiter.
module tb_regfile_wr_arbiter;

  typedef struct {
    logic [2:0]  req;
    logic [8:0]  wa;
    logic [44:0] wd;
    logic [2:0]  gnt;
    logic        we;
    logic [2:0]  owa;
    logic [14:0] owd;
    logic        err;
    logic [2:0]  err_id;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [8:0]  req_wa;
  logic [44:0] req_wd;
  logic [2:0]  gnt;
  logic [2:0]  wa;
  logic [14:0] wd;
  logic        we;
  logic        err;
  logic [2:0]  err_id;
`ifdef WRARB_LOCK_EN
  logic [2:0]  lock;
`endif

  int errors = 0;
  int checks = 0;

  logic [14:0] rf [0:6];
  int          order[$];
  logic        ewe, eerr;
  logic [2:0]  ewa, eid;
  logic [14:0] ewd;
  vec_t        vecs[18];

  regfile_wr_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .REQ    (req),
    .REQ_WA (req_wa),
    .REQ_WD (req_wd),
`ifdef WRARB_LOCK_EN
    .LOCK   (lock),
`endif
    .GNT    (gnt),
    .WA     (wa),
    .WD     (wd),
    .WE     (we),
    .ERR    (err),
    .ERR_ID (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file behind the write port.
  always @(posedge clk) if (we && wa < 3'd7) rf[wa] <= wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] r, input logic [8:0] a, input logic [44:0] d,
                              input logic [2:0] g, input logic e, input logic [2:0] oa,
                              input logic [14:0] od, input logic er, input logic [2:0] id);
    vec_t v;
    v.req = r; v.wa = a; v.wd = d; v.gnt = g; v.we = e;
    v.owa = oa; v.owd = od; v.err = er; v.err_id = id;
    return v;
  endfunction

  // Reference: priority order kept as a rotating list of requester ids.
  function automatic int model_pick(input logic [2:0] r);
    foreach (order[i]) if (r[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic model_advance(input int k, input logic locked);
    int x;
    if (locked) begin
      while (order[0] != k) begin x = order.pop_front(); order.push_back(x); end
    end else begin
      do begin x = order.pop_front(); order.push_back(x); end while (x != k);
    end
  endtask

  task automatic model_reset();
    order = {0, 1, 2};
    ewe = 1'b0; eerr = 1'b0; ewa = 3'd0; ewd = 15'd0; eid = 3'd0;
  endtask

  task automatic do_reset();
    req = 3'b000;
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic e, input logic [2:0] a, input logic [14:0] d,
                          input logic er, input logic [2:0] id);
    chk({tag, ".we"}, 32'(we), 32'(e));
    chk({tag, ".wa"}, 32'(wa), 32'(a));
    chk({tag, ".wd"}, 32'(wd), 32'(d));
    chk({tag, ".err"}, 32'(err), 32'(er));
    chk({tag, ".err_id"}, 32'(err_id), 32'(id));
  endtask

  initial begin
    logic [8:0]  a_rr;
    logic [44:0] d_rr;
    logic [14:0] rf_exp [0:6];
    int          k;
    logic [2:0]  a;

    a_rr = {3'd6, 3'd1, 3'd0};
    d_rr = {15'h0266, 15'h0111, 15'h0100};
    for (int i = 0; i < 6; i++)
      vecs[i] = mk(3'b111, a_rr, d_rr, 3'b001 << (i % 3), 1'b1, a_rr[(i%3)*3 +: 3],
                   d_rr[(i%3)*15 +: 15], 1'b0, 3'd0);
    for (int i = 6; i < 9; i++)
      vecs[i] = mk(3'b010, {3'd0, 3'd5, 3'd0}, {15'h0, 15'h0005, 15'h0}, 3'b010, 1'b1, 3'd5,
                   15'h0005, 1'b0, 3'd0);
    vecs[9]  = mk(3'b100, {3'd7, 3'd5, 3'd0}, {15'h7FFF, 15'h0005, 15'h0}, 3'b100, 1'b0, 3'd5,
                  15'h0005, 1'b1, 3'd2);
    vecs[10] = mk(3'b000, 9'd0, 45'd0, 3'b000, 1'b0, 3'd5, 15'h0005, 1'b0, 3'd2);
    vecs[11] = mk(3'b001, {3'd0, 3'd0, 3'd3}, {15'h0, 15'h0, 15'h1234}, 3'b001, 1'b1, 3'd3,
                  15'h1234, 1'b0, 3'd2);
    vecs[12] = mk(3'b011, {3'd0, 3'd4, 3'd3}, {15'h0, 15'h4444, 15'h1234}, 3'b010, 1'b1, 3'd4,
                  15'h4444, 1'b0, 3'd2);
    vecs[13] = mk(3'b000, 9'd0, 45'd0, 3'b000, 1'b0, 3'd4, 15'h4444, 1'b0, 3'd2);
    vecs[14] = mk(3'b101, {3'd2, 3'd0, 3'd3}, {15'h2222, 15'h0, 15'h1234}, 3'b100, 1'b1, 3'd2,
                  15'h2222, 1'b0, 3'd2);
    vecs[15] = mk(3'b101, {3'd2, 3'd0, 3'd3}, {15'h2222, 15'h0, 15'h1234}, 3'b001, 1'b1, 3'd3,
                  15'h1234, 1'b0, 3'd2);
    vecs[16] = mk(3'b110, {3'd7, 3'd7, 3'd0}, {15'h0ABC, 15'h0DEF, 15'h0}, 3'b010, 1'b0, 3'd3,
                  15'h1234, 1'b1, 3'd1);
    vecs[17] = mk(3'b110, {3'd7, 3'd7, 3'd0}, {15'h0ABC, 15'h0DEF, 15'h0}, 3'b100, 1'b0, 3'd3,
                  15'h1234, 1'b1, 3'd2);
    rf_exp = '{15'h0100, 15'h0111, 15'h2222, 15'h1234, 15'h4444, 15'h0005, 15'h0266};

    rst = 1'b1; req = 3'b000; req_wa = '0; req_wd = '0;
`ifdef WRARB_LOCK_EN
    lock = 3'b000;
`endif
    #12;
    chk("reset.gnt", 32'(gnt), 32'd0);
    chk_regs("reset", 1'b0, 3'd0, 15'd0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      req = vecs[i].req; req_wa = vecs[i].wa; req_wd = vecs[i].wd;
      #1;
      chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      @(posedge clk);
      #1;
      chk_regs($sformatf("vec%0d", i), vecs[i].we, vecs[i].owa, vecs[i].owd, vecs[i].err,
               vecs[i].err_id);
    end
    req = 3'b000;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) chk($sformatf("rf[%0d]", i), 32'(rf[i]), 32'(rf_exp[i]));

`ifdef WRARB_LOCK_EN
    do_reset();
    req = 3'b001; lock = 3'b000;
    @(posedge clk); #1;
    req = 3'b011; lock = 3'b010;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lock%0d.gnt", i), 32'(gnt), 32'b010);
      @(posedge clk); #1;
    end
    lock = 3'b000;
    chk("unlock.gnt", 32'(gnt), 32'b010);
    @(posedge clk); #1;
    chk("after_unlock.gnt", 32'(gnt), 32'b001);
    req = 3'b000;
`endif

    do_reset();
    for (int n = 0; n < 400; n++) begin
      req    = 3'($urandom);
      req_wa = 9'($urandom);
      req_wd = {13'($urandom), 32'($urandom)};
`ifdef WRARB_LOCK_EN
      lock   = 3'($urandom) & 3'($urandom);
`endif
      #1;
      k = model_pick(req);
      chk("rand.gnt", 32'(gnt), (k < 0) ? 32'd0 : (32'd1 << k));
      ewe = 1'b0; eerr = 1'b0;
      if (k >= 0) begin
        a = req_wa[k*3 +: 3];
        if (a < 3'd7) begin
          ewe = 1'b1; ewa = a; ewd = req_wd[k*15 +: 15];
        end else begin
          eerr = 1'b1; eid = 3'(k);
        end
`ifdef WRARB_LOCK_EN
        model_advance(k, lock[k]);
`else
        model_advance(k, 1'b0);
`endif
      end
      @(posedge clk);
      #1;
      chk_regs("rand", ewe, ewa, ewd, eerr, eid);
    end

`ifdef WRARB_LOCK_EN
    lock = 3'b000;
`endif
    req = 3'b111; req_wa = {3'd3, 3'd2, 3'd1}; req_wd = {15'h0333, 15'h0222, 15'h0111};
    @(posedge clk);
    #1;
    chk("midrst.pre_we", 32'(we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.gnt", 32'(gnt), 32'd0);
    chk("midrst.we", 32'(we), 32'd0);
    chk("midrst.err", 32'(err), 32'd0);
    chk("midrst.wa", 32'(wa), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release.gnt", 32'(gnt), 32'b001);
    @(posedge clk);
    #1;
    chk_regs("release", 1'b1, 3'd1, 15'h0111, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port (WA/WD/WE) of the 7-entry x 15-bit register file between NREQ requesters. Uses a per-requester req/gnt handshake, registers the winning write onto the register-file write port, and rejects writes to the unimplemented address 7. Sits directly in front of the register file write port; the read ports are not touched.

Parameters:
NREQ, 3, number of write requesters (2..8)
AW, 3, register-file address width
DW, 15, register-file data width
DEPTH, 7, number of implemented entries; addresses >= DEPTH are illegal

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
REQ  input  NREQ  per-requester write request, bit i = requester i
REQ_WA  input  NREQ*AW  packed write addresses, slice i = [i*AW +: AW]
REQ_WD  input  NREQ*DW  packed write data, slice i = [i*DW +: DW]
GNT  output  NREQ  one-hot grant (combinational); transfer when REQ[i] & GNT[i] at posedge
WA  output  AW  register-file write address (registered)
WD  output  DW  register-file write data (registered)
WE  output  1  register-file write enable (registered)
ERR  output  1  one-cycle pulse: a granted write targeted an illegal address
ERR_ID  output  3  index of the requester that caused the last ERR (held until next ERR)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: WE=0, WA=0, WD=0, ERR=0, ERR_ID=0, priority pointer PTR=0. GNT is 0 while rst is high.
- Arbitration: combinational. GNT = one-hot of the first set REQ bit searched from PTR upward, wrapping modulo NREQ. GNT=0 when REQ=0. At most one GNT bit is ever set.
- Handshake: the requester holds REQ, REQ_WA and REQ_WD stable until it sees GNT high at a posedge. Transfer occurs at that edge. It may keep REQ high for back-to-back writes. It may drop REQ before being granted; no state is kept.
- PTR update: on a transfer by requester k, PTR <= (k+1) mod NREQ. With no transfer, PTR holds.
- Write port: on a transfer at edge E with address < DEPTH, WE=1, WA=address and WD=data for the cycle after E, so the register file writes at edge E+1. Otherwise WE=0 at E+1. WA/WD hold their last value when WE=0.
- Throughput: one write per cycle. A continuous single requester gets 100% of the slots. With N active requesters each is granted exactly once per N cycles.
- Illegal address (REQ_WA slice >= DEPTH, i.e. 7): the grant is still given and the request is consumed. WE stays 0, ERR=1 for one cycle after the transfer, and ERR_ID=k. PTR advances normally.
- Simultaneous requests at reset release: requester 0 wins first.
- Reset mid-operation: outputs clear immediately (asynchronously). An in-flight registered write is dropped (WE forced 0). PTR returns to 0.
- No combinational path from WA/WD/WE back to GNT.

Optional Feature:
WRARB_LOCK_EN: adds input port LOCK (width NREQ).
- With the macro defined: if requester k transfers with LOCK[k]=1, PTR <= k instead of k+1. Requester k then keeps winning while REQ[k] stays high (burst). The first transfer with LOCK[k]=0, or a cycle with REQ[k]=0, ends the burst, and round-robin resumes from k+1 after its next transfer.
- Without the macro: no LOCK port; pure round-robin as above.

Test Plan:
- Reset: assert rst mid-cycle with REQ=3'b111 -> WE=0, ERR=0, GNT=0 immediately. Release rst -> GNT=3'b001 in the first cycle.
- Single requester: REQ=3'b010, REQ_WA slice1=5, WD=15'h0005 for 3 cycles -> GNT[1]=1 every cycle; WE=1, WA=5, WD=15'h0005 on cycles 2-4; a register-file read of RA1=5 returns 15'h0005.
- Round-robin: REQ=3'b111 held 6 cycles with addresses 0, 1, 6 -> GNT sequence 001, 010, 100, 001, 010, 100; WA sequence 0, 1, 6, 0, 1, 6, each one cycle later.
- Illegal address: requester 2 with REQ_WA=7, WD=15'h7FFF -> GNT[2]=1; next cycle WE=0, ERR=1, ERR_ID=2; the register-file contents are unchanged.
- Late request / drop: REQ[0] is raised while requester 1 holds the grant, then dropped before being granted -> no write for requester 0, PTR unaffected.
- (WRARB_LOCK_EN) LOCK[1]=1 with REQ=3'b011 for 4 cycles -> GNT=010 for all 4. Deasserting LOCK[1] -> the next grant after requester 1's transfer goes to requester 0.
